clk_src_sel_ctrl: RTL

- Control stage directly upstream of the board-clock source mux. That mux selects the differential-buffered 125 MHz clock when sel=1 and the single-ended 25 MHz path when sel=0.
- The block runs on an always-on reference clock and measures the activity of both candidate clocks through divided toggle signals. It decides which source is healthy and drives the mux select.
- Each select change is bracketed by a clock-enable gap, so the non-glitch-free mux is only switched while its output is gated off downstream.

---
 rtl/clk_src_sel_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/clk_src_sel_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// clk_src_sel_ctrl : clock-source health monitor and gapped mux-select control
// Rev 1.0
// -----------------------------------------------------------------------------
module clk_src_sel_ctrl #(
  parameter int WIN_CYCLES = 1000,
  parameter int CNT_W      = 12,
  parameter int PRI_MIN    = 70,
  parameter int PRI_MAX    = 86,
  parameter int SEC_MIN    = 12,
  parameter int SEC_MAX    = 20,
  parameter int GOOD_WIN   = 4,
  parameter int GAP        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pri_tgl,
  input  logic sec_tgl,
  input  logic force_sec,
  output logic sel,
  output logic clk_en,
  output logic pri_ok,
  output logic sec_ok,
  output logic switched
);

  localparam int WIN_W = $clog2(WIN_CYCLES);
  localparam int GAP_W = $clog2(GAP);
  localparam int STK_W = $clog2(GOOD_WIN + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
  localparam logic [GAP_W-1:0] GAP_PRE  = GAP_W'(GAP / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [STK_W-1:0] STK_FULL = STK_W'(GOOD_WIN);
  localparam logic [STK_W-1:0] STK_LAST = STK_W'(GOOD_WIN - 1);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_SEL_PRI = 3'd1,
    ST_SEL_SEC = 3'd2,
    ST_GAP_PRI = 3'd3,
    ST_GAP_SEC = 3'd4
  } state_t;

  logic [WIN_W-1:0] win_cnt;
  logic             win_end;
  logic [1:0]       tgl_in;
  logic [1:0]       ok;

  assign tgl_in  = {sec_tgl, pri_tgl};
  assign win_end = (win_cnt == WIN_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          win_cnt <= '0;
    else if (win_end) win_cnt <= '0;
    else              win_cnt <= win_cnt + WIN_W'(1);
  end

  // Index 0 measures the primary source, index 1 the secondary.
  for (genvar i = 0; i < 2; i++) begin : g_src
    localparam logic [CNT_W-1:0] LO = (i == 0) ? CNT_W'(PRI_MIN) : CNT_W'(SEC_MIN);
    localparam logic [CNT_W-1:0] HI = (i == 0) ? CNT_W'(PRI_MAX) : CNT_W'(SEC_MAX);

    logic [2:0]       sync;
    logic             tgl_edge;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_eval;
    logic [STK_W-1:0] streak;
    logic             win_good;
    logic             ok_q;

    // sync[1] is the synchronised level, sync[2] its history.
    assign tgl_edge = sync[1] ^ sync[2];
    assign cnt_eval = (tgl_edge && (cnt != CNT_SAT)) ? cnt + CNT_W'(1) : cnt;
    assign win_good = (cnt_eval >= LO) && (cnt_eval <= HI);
    assign ok[i]    = ok_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync   <= '0;
        cnt    <= '0;
        streak <= '0;
        ok_q   <= 1'b0;
      end else begin
        sync <= {sync[1:0], tgl_in[i]};
        if (win_end) begin
          cnt <= '0;
          if (win_good) begin
            if (streak != STK_FULL) streak <= streak + STK_W'(1);
            ok_q <= (streak >= STK_LAST);
          end else begin
            streak <= '0;
            ok_q   <= 1'b0;
          end
        end else begin
          cnt <= cnt_eval;
        end
      end
    end
  end

  assign pri_ok = ok[0];
  assign sec_ok = ok[1];

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             sel_nxt, en_nxt, sw_nxt;
  logic             target_pri;

  assign target_pri = pri_ok && !(force_sec && sec_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      gap_cnt  <= '0;
      sel      <= 1'b1;
      clk_en   <= 1'b0;
      switched <= 1'b0;
    end else begin
      state    <= state_nxt;
      gap_cnt  <= gap_nxt;
      sel      <= sel_nxt;
      clk_en   <= en_nxt;
      switched <= sw_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    sel_nxt   = sel;
    en_nxt    = clk_en;
    sw_nxt    = 1'b0;
    case (state)
      ST_INIT: begin
        // Clocks are gated here, so select is parked on primary; enabling
        // waits until that parked value has actually reached the mux.
        en_nxt  = 1'b0;
        sel_nxt = 1'b1;
        if (target_pri) begin
          if (sel) begin
            state_nxt = ST_SEL_PRI;
            en_nxt    = 1'b1;
          end
        end else if (sec_ok) begin
          state_nxt = ST_GAP_SEC;
          gap_nxt   = '0;
        end
      end
      ST_SEL_PRI: begin
        if (!target_pri && sec_ok) begin
          state_nxt = ST_GAP_SEC;
          gap_nxt   = '0;
          en_nxt    = 1'b0;
        end else if (!pri_ok && !sec_ok) begin
          state_nxt = ST_INIT;
          en_nxt    = 1'b0;
        end
      end
      ST_SEL_SEC: begin
        if (target_pri || (pri_ok && !sec_ok)) begin
          state_nxt = ST_GAP_PRI;
          gap_nxt   = '0;
          en_nxt    = 1'b0;
        end else if (!pri_ok && !sec_ok) begin
          state_nxt = ST_INIT;
          en_nxt    = 1'b0;
        end
      end
      ST_GAP_PRI, ST_GAP_SEC: begin
        en_nxt = 1'b0;
        if (gap_cnt == GAP_LAST) begin
          state_nxt = (state == ST_GAP_PRI) ? ST_SEL_PRI : ST_SEL_SEC;
          en_nxt    = 1'b1;
          sw_nxt    = 1'b1;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
          if (gap_cnt == GAP_PRE) sel_nxt = (state == ST_GAP_PRI);
        end
      end
      default: begin
        state_nxt = ST_INIT;
        en_nxt    = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
